sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO with valid/ready handshakes on both the producer and consumer sides. It replaces the fixed 4-bit x 10 fifo, which was unclocked and stopped simulation on full. This block adds backpressure, configurable data width and depth (any depth, not only powers of two), an occupancy count, almost-full/almost-empty thresholds and a synchronous flush. It buffers data between AHB-side producers (master/slave data paths) and consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, any integer)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of contents
wr_valid  in  1  producer offers wr_data
wr_ready  out  1  FIFO can accept; push = wr_valid & wr_ready
wr_data  in  WIDTH  producer data
rd_valid  out  1  head entry available; equals !empty
rd_ready  in  1  consumer takes head; pop = rd_valid & rd_ready
rd_data  out  WIDTH  head entry (show-ahead)
count  out  CW=$clog2(DEPTH+1)  current occupancy 0..DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Outputs: wr_ready=1, rd_valid=0, count=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal AF_LEVEL. Storage is not cleared. rd_data is don't-care while rd_valid=0.
- Reset mid-operation discards all contents immediately. The first push after release is accepted on the first clk edge with rst=0.
- Storage: DEPTH x WIDTH register array. wr_ptr/rd_ptr range 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- wr_ready = (count != DEPTH), combinational from registered count. rd_valid = (count != 0).
- Push: mem[wr_ptr] <= wr_data; wr_ptr advances.
- Pop: rd_ptr advances.
- rd_data = mem[rd_ptr] (show-ahead, no read latency).
- count: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
- Latency: a word pushed into an empty FIFO at edge N has rd_valid=1 and rd_data valid after edge N. Write-to-read latency is 1 cycle. No same-cycle bypass.
- Full (count=DEPTH): wr_ready=0. A push is blocked even if a pop occurs that cycle; wr_ready returns to 1 the cycle after the pop.
- Empty: rd_valid=0 and pop is impossible. rd_ready while empty has no effect.
- Simultaneous push and pop at 0<count<DEPTH: both pointers advance, count holds, and data ordering is preserved.
- flush=1 at an edge: pointers and count go to 0. Flush has priority over a same-cycle push and pop (both are dropped). wr_ready stays as computed from count and is not gated by flush.
- almost_full/almost_empty are combinational from count, so they update together with count.
- Ordering: strict FIFO with no loss or duplication. No transfer occurs without the handshake.
- No $finish or simulation-only constructs. Fully synthesizable.

Test Plan:
- Reset/idle: assert rst mid-cycle for 2 cycles -> wr_ready=1, rd_valid=0, count=0, almost_empty=1, almost_full=0, held while rst=1.
- Fill/drain, DEPTH=10: push 0x01..0x0A with rd_ready=0 -> count reaches 10, wr_ready=0, almost_full=1 from count=8. Attempt 11th push of 0xFF -> not accepted. Drain with rd_ready=1 -> reads 0x01..0x0A in order, then rd_valid=0 and count=0.
- Wrap-around: push 7 and pop 7, then push 10 and pop 10 (pointers cross index 9->0) -> exact order preserved, count never exceeds 10.
- Simultaneous at full: count=10, wr_valid=1 and rd_ready=1 -> only the pop occurs, count=9, and the next-cycle push is accepted back to count=10.
- Simultaneous mid-level: count=4, continuous push and pop for 20 cycles with random data -> count stays 4, output stream equals input stream delayed by 4 words.
- Flush priority: count=5, flush=1 with wr_valid=1 and rd_ready=1 -> next cycle count=0 and rd_valid=0. The pushed word is absent, and a later push of 0x3C reads back as 0x3C.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock valid/ready FIFO with any depth, show-ahead read,
//               occupancy count, almost-full/almost-empty flags and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_AF       = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE       = c_CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // Handshake status comes only from the registered count, so a pop in the
    // same cycle never opens a slot for a push while full.
    assign wr_ready     = (r_count != c_CNT_FULL);
    assign rd_valid     = (r_count != '0);
    assign w_push       = wr_valid & wr_ready;
    assign w_pop        = rd_valid & rd_ready;

    assign rd_data      = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);

    // Storage carries no reset; stale words are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap by explicit compare so DEPTH need not be 2^n.
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param (vector table, corner
//               sequences and random traffic against a queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 10;
    localparam int AF    = 8;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];

    typedef struct {
        logic             wv;
        logic [WIDTH-1:0] wd;
        logic             rr;
        int               cnt;
        logic             rv;
        logic             wrdy;
        logic [WIDTH-1:0] rd;
        logic             af;
        logic             ae;
    } vec_t;

    vec_t tbl[21];

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected flags follow directly from the occupancy of the model queue.
    task automatic chk_model(input string tag);
        int n;
        n = q.size();
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(n != 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        if (n > 0) chk({tag, " rd_data"}, 32'(rd_data), 32'(q[0]));
    endtask

    // One clock: inputs are applied before the edge, the model advances at the
    // edge, and outputs are ready to sample 1 time unit later.
    task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd,
                         input logic rr, input logic fl);
        int  n;
        logic do_push, do_pop;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        n        = q.size();
        do_push  = wv && (n < DEPTH);
        do_pop   = rr && (n > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(wd);
        end
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        // Fill 0x01..0x0A, refused 11th push of 0xFF, then drain in order.
        for (int k = 1; k <= 10; k++) begin
            tbl[k-1] = '{wv: 1'b1, wd: WIDTH'(k), rr: 1'b0, cnt: k, rv: 1'b1,
                         wrdy: (k != DEPTH), rd: 8'h01, af: (k >= AF), ae: (k <= AE)};
        end
        tbl[10] = '{wv: 1'b1, wd: 8'hFF, rr: 1'b0, cnt: 10, rv: 1'b1,
                    wrdy: 1'b0, rd: 8'h01, af: 1'b1, ae: 1'b0};
        for (int j = 1; j <= 10; j++) begin
            tbl[10+j] = '{wv: 1'b0, wd: 8'h00, rr: 1'b1, cnt: 10 - j, rv: (j != 10),
                          wrdy: 1'b1, rd: WIDTH'(j + 1), af: ((10 - j) >= AF),
                          ae: ((10 - j) <= AE)};
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_model("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_model("idle");

        for (int i = 0; i < 21; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cycle(tbl[i].wv, tbl[i].wd, tbl[i].rr, 1'b0);
            chk({nm, " count"}, 32'(count), 32'(tbl[i].cnt));
            chk({nm, " rd_valid"}, 32'(rd_valid), 32'(tbl[i].rv));
            chk({nm, " wr_ready"}, 32'(wr_ready), 32'(tbl[i].wrdy));
            chk({nm, " almost_full"}, 32'(almost_full), 32'(tbl[i].af));
            chk({nm, " almost_empty"}, 32'(almost_empty), 32'(tbl[i].ae));
            if (tbl[i].rv) chk({nm, " rd_data"}, 32'(rd_data), 32'(tbl[i].rd));
        end

        // Wrap-around: 7 in/out, then 10 in/out crossing index 9 -> 0.
        for (int i = 0; i < 7; i++)  begin cycle(1'b1, WIDTH'(8'h10 + i), 1'b0, 1'b0); chk_model("wrap_a_push"); end
        for (int i = 0; i < 7; i++)  begin cycle(1'b0, '0, 1'b1, 1'b0); chk_model("wrap_a_pop"); end
        for (int i = 0; i < 10; i++) begin cycle(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0); chk_model("wrap_b_push"); end
        for (int i = 0; i < 10; i++) begin cycle(1'b0, '0, 1'b1, 1'b0); chk_model("wrap_b_pop"); end

        // Push and pop together at full: only the pop happens.
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        chk_model("full");
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_simul count", 32'(count), 32'd9);
        chk("full_simul wr_ready", 32'(wr_ready), 32'd1);
        chk_model("full_simul");
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        chk("full_refill count", 32'(count), 32'd10);
        chk_model("full_refill");
        while (q.size() > 0) begin cycle(1'b0, '0, 1'b1, 1'b0); chk_model("full_drain"); end

        // Continuous push and pop at count 4.
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
            chk("mid count", 32'(count), 32'd4);
            chk_model("mid");
        end

        // Flush wins over a same-cycle push and pop.
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("pre_flush count", 32'(count), 32'd5);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush count", 32'(count), 32'd0);
        chk("flush rd_valid", 32'(rd_valid), 32'd0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_flush rd_data", 32'(rd_data), 32'h3C);
        chk_model("post_flush");
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk_model("post_flush_pop");

        // Asynchronous reset in the middle of a cycle, held for two edges.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h90 + i), 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        chk_model("async_rst");
        repeat (2) begin
            wr_valid = 1'b1;
            wr_data  = 8'hEE;
            @(posedge clk);
            #1;
            chk_model("rst_held");
        end
        rst = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("first_push count", 32'(count), 32'd1);
        chk_model("first_push");

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 60), WIDTH'($urandom),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
